inst_fetch_unit: RTL and testbench

//  Reader side of the PC interface. Takes the PC register value, fetches the

---
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetches the word at the PC register value over a
// req/gnt/rvalid memory port and hands {pc, instr} to decode via valid/ready.
module inst_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_fault_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DROP  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t          state;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] hold_instr;
  logic            req_gap;
  logic            slot_free;
  logic            misaligned;
  logic            advance;

  // Memory request and PC-advance strobes follow the current state and inputs.
  always_comb begin
    slot_free   = !if_valid_o || if_ready_i;
    misaligned  = (pc_i[1:0] != 2'b00);
    imem_req_o  = (state == S_REQ) && !misaligned && !req_gap;
    imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
    advance     = !flush_i && slot_free &&
                  (((state == S_WAIT) && imem_rvalid_i) || (state == S_HOLD));
    pc_stall_o  = !(advance || flush_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      req_pc     <= '0;
      hold_instr <= '0;
      req_gap    <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
      if_fault_o <= 1'b0;
    end else begin
      req_gap <= 1'b0;
      // A completed transfer empties the slot unless a new entry loads below.
      if (if_valid_o && if_ready_i) begin
        if_valid_o <= 1'b0;
        if_instr_o <= NOP_INSTR;
        if_fault_o <= 1'b0;
      end

      if (flush_i) begin
        if_valid_o <= 1'b0;
        if_instr_o <= NOP_INSTR;
        if_fault_o <= 1'b0;
        unique case (state)
          S_REQ: begin
            if (imem_req_o && imem_gnt_i) begin
              state <= S_DROP;
            end else begin
              state   <= S_REQ;
              req_gap <= 1'b1;
            end
          end
          S_WAIT, S_DROP: state <= imem_rvalid_i ? S_REQ : S_DROP;
          default:        state <= S_REQ;
        endcase
      end else begin
        unique case (state)
          S_IDLE: state <= S_REQ;
          S_REQ: begin
            if (misaligned) begin
              if (slot_free) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc_i;
                if_instr_o <= NOP_INSTR;
                if_fault_o <= 1'b1;
                state      <= S_FAULT;
              end
            end else if (imem_req_o && imem_gnt_i) begin
              req_pc <= pc_i;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (slot_free) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= req_pc;
                if_instr_o <= imem_rdata_i;
                if_fault_o <= 1'b0;
                state      <= S_REQ;
              end else begin
                hold_instr <= imem_rdata_i;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (slot_free) begin
              if_valid_o <= 1'b1;
              if_pc_o    <= req_pc;
              if_instr_o <= hold_instr;
              if_fault_o <= 1'b0;
              state      <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem_rvalid_i) state <= S_REQ;
          end
          S_FAULT: state <= S_FAULT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: PC register, randomized memory and decode models,
// and a scoreboard comparing the decode stream to the program-order model.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_fault_o;

  inst_fetch_unit #(.NOP_INSTR(NOP)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_stall_o    (pc_stall_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_fault_o    (if_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // PC register: advances by 4 when released, loads the redirect target on flush.
  logic [31:0] pc_reg;
  logic [31:0] flush_target = 32'h0;
  assign pc_i = pc_reg;
  always @(posedge clk_i) begin
    if (rst_i)            pc_reg <= 32'h0;
    else if (flush_i)     pc_reg <= flush_target;
    else if (!pc_stall_o) pc_reg <= pc_reg + 32'd4;
  end

  // Instruction memory: random grant, one outstanding read, latency 1..max_lat.
  int          gnt_pct   = 100;
  int          max_lat   = 1;
  int          fixed_lat = 0;
  bit          pend      = 1'b0;
  int          lat       = 0;
  logic [31:0] paddr     = 32'h0;

  always @(negedge clk_i) begin
    #1;
    imem_rvalid_i = pend && (lat == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_word(paddr) : $urandom();
    imem_gnt_i    = imem_req_o && !pend && (int'($urandom_range(99)) < gnt_pct);
  end

  always @(posedge clk_i) begin
    if (imem_rvalid_i)         pend <= 1'b0;
    else if (pend && lat > 0)  lat  <= lat - 1;
    if (imem_req_o && imem_gnt_i) begin
      pend  <= 1'b1;
      paddr <= imem_addr_o;
      lat   <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(max_lat - 1, 0));
    end
  end

  int ready_pct = 100;
  always @(negedge clk_i) begin
    #1;
    if_ready_i = (int'($urandom_range(99)) < ready_pct);
  end

  // Expected decode stream: program order from the last redirect target.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  task automatic load_program(input logic [31:0] target);
    exp_t e;
    exp_q.delete();
    if (target[1:0] != 2'b00) begin
      e.pc = target; e.instr = NOP; e.fault = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 256; i++) begin
        e.pc    = target + 32'(4 * i);
        e.instr = mem_word(e.pc);
        e.fault = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: sampled just before each rising edge.
  logic        held = 1'b0;
  logic [31:0] held_pc, held_instr;
  logic        held_fault;
  always @(negedge clk_i) begin
    exp_t e;
    #4;
    if (rst_i) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stable_valid", 32'(if_valid_o), 32'd1);
        chk("stable_pc", if_pc_o, held_pc);
        chk("stable_instr", if_instr_o, held_instr);
        chk("stable_fault", 32'(if_fault_o), 32'(held_fault));
      end
      if (!if_valid_o) chk("empty_instr_nop", if_instr_o, NOP);
      if (if_valid_o && if_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry_pc", if_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc_o, e.pc);
          chk("sb_instr", if_instr_o, e.instr);
          chk("sb_fault", 32'(if_fault_o), 32'(e.fault));
          consumed++;
        end
      end
      held       = if_valid_o && !if_ready_i && !flush_i;
      held_pc    = if_pc_o;
      held_instr = if_instr_o;
      held_fault = if_fault_o;
    end
  end

  task automatic do_flush(input logic [31:0] target);
    @(negedge clk_i);
    flush_target = target;
    flush_i      = 1'b1;
    load_program(target);
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  // Called at a sample point; returns at the sample point of a request cycle.
  task automatic wait_req(input string name, input bit adv);
    int n = 0;
    if (adv) begin @(negedge clk_i); #4; end
    while (!imem_req_o && n < 50) begin
      @(negedge clk_i); #4; n++;
    end
    if (!imem_req_o) chk(name, 32'(imem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid_o && n < 50) begin
      @(negedge clk_i); #4; n++;
    end
    if (!if_valid_o) chk(name, 32'(if_valid_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    load_program(32'h0);
    // T1: reset held for two edges, then released
    @(negedge clk_i);
    @(negedge clk_i); #4;
    chk("t1_rst_valid", 32'(if_valid_o), 32'd0);
    chk("t1_rst_req", 32'(imem_req_o), 32'd0);
    chk("t1_rst_stall", 32'(pc_stall_o), 32'd1);
    chk("t1_rst_pc", if_pc_o, 32'h0);
    @(negedge clk_i); rst_i = 1'b0; #4;
    chk("t1_idle_req", 32'(imem_req_o), 32'd0);
    chk("t1_idle_stall", 32'(pc_stall_o), 32'd1);
    @(negedge clk_i); #4;
    chk("t1_first_req", 32'(imem_req_o), 32'd1);
    chk("t1_first_addr", imem_addr_o, 32'h0);

    // T2: zero-wait stream, one entry and one stall-low every two cycles
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i); #4;
      chk("t2_valid", 32'(if_valid_o), 32'(k % 2));
      chk("t2_stall", 32'(pc_stall_o), 32'(k % 2));
      if (k % 2 == 1) chk("t2_pc", if_pc_o, 32'(4 * (k / 2)));
    end

    // T3: backpressure parks the next fetch in the hold buffer
    ready_pct = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i); #4;
      if (k >= 5) begin
        chk("t3_valid", 32'(if_valid_o), 32'd1);
        chk("t3_pc", if_pc_o, 32'hC);
        chk("t3_no_req", 32'(imem_req_o), 32'd0);
        chk("t3_stall", 32'(pc_stall_o), 32'd1);
      end
    end
    ready_pct = 100;
    for (int k = 0; k < 4; k++) begin @(negedge clk_i); #4; end

    // T4: flush while a slow read of 0x10 is outstanding
    fixed_lat = 2;
    do_flush(32'h10); #4;
    wait_req("t4_req10_timeout", 1'b0);
    chk("t4_addr10", imem_addr_o, 32'h10);
    do_flush(32'h40); #4;
    chk("t4_valid_after_flush", 32'(if_valid_o), 32'd0);
    wait_req("t4_req40_timeout", 1'b0);
    chk("t4_addr40", imem_addr_o, 32'h40);
    chk("t4_old_read_done", 32'(pend), 32'd0);

    // T5: flush coincident with rvalid, then flush in REQ before grant
    fixed_lat = 0;
    wait_req("t5_req_timeout", 1'b1);
    do_flush(32'h80); #4;
    chk("t5a_valid_after_flush", 32'(if_valid_o), 32'd0);
    wait_req("t5a_req_timeout", 1'b0);
    chk("t5a_addr80", imem_addr_o, 32'h80);
    gnt_pct = 0;
    wait_req("t5b_req_timeout", 1'b1);
    do_flush(32'hC0); #4;
    chk("t5b_valid_after_flush", 32'(if_valid_o), 32'd0);
    chk("t5b_req_gap", 32'(imem_req_o), 32'd0);
    gnt_pct = 100;
    wait_req("t5b_reqc0_timeout", 1'b0);
    chk("t5b_addrC0", imem_addr_o, 32'hC0);

    // T6: misaligned PC faults and parks until redirected
    ready_pct = 0;
    do_flush(32'h22); #4;
    wait_valid("t6_fault_timeout");
    chk("t6_fault", 32'(if_fault_o), 32'd1);
    chk("t6_pc", if_pc_o, 32'h22);
    chk("t6_instr", if_instr_o, NOP);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); #4;
      chk("t6_no_req", 32'(imem_req_o), 32'd0);
      chk("t6_stall", 32'(pc_stall_o), 32'd1);
    end
    ready_pct = 100;
    for (int k = 0; k < 3; k++) begin @(negedge clk_i); #4; end
    chk("t6_still_no_req", 32'(imem_req_o), 32'd0);
    do_flush(32'h100); #4;
    wait_req("t6_req100_timeout", 1'b0);
    chk("t6_addr100", imem_addr_o, 32'h100);

    // Random traffic: grant, latency, backpressure and redirects all randomized
    gnt_pct   = 70;
    fixed_lat = -1;
    max_lat   = 4;
    ready_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(24) == 0) begin
        logic [31:0] t;
        t = {20'h0, 10'($urandom_range(1023)), 2'b00};
        if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
        do_flush(t);
      end else begin
        @(negedge clk_i);
      end
    end
    for (int k = 0; k < 4; k++) @(negedge clk_i);
    #4;
    chk("progress", 32'(consumed > 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
